// File: rtl/button_debounce_pkg.sv
// Shared types and default timing for the user-button debouncer.
// Defaults assume the 12 MHz board clock.
package button_debounce_pkg;

   typedef enum logic [2:0] {
      RELEASED     = 3'd0,
      PRESS_WAIT   = 3'd1,
      PRESSED      = 3'd2,
      LONG_HELD    = 3'd3,
      RELEASE_WAIT = 3'd4
   } db_state_t;

   localparam int CLK_HZ              = 12_000_000;
   localparam int DEBOUNCE_MS         = 10;
   localparam int LONG_MS             = 1000;
   localparam int DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int DEF_LONG_CYCLES     = (CLK_HZ / 1000) * LONG_MS;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VALUE
// lets idle-high lines (button, UART RX) come out of reset inactive.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// Debounces the active-low user button and produces level, press/release
// and long-press strobes plus a wrapping press counter; all outputs registered.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_n_in,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic [7:0] press_count
);

   localparam int DEB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam int HOLD_W = cnt_width(LONG_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   db_state_t         state;
   logic [DEB_W-1:0]  deb_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              long_seen;
   logic              btn_n_sync;
   logic              sync_pressed;

   sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_n_in),
      .q   (btn_n_sync)
   );

   assign sync_pressed = ~btn_n_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RELEASED;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         long_seen     <= 1'b0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         press_count   <= '0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         case (state)
            RELEASED: begin
               if (sync_pressed) begin
                  state   <= PRESS_WAIT;
                  deb_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync_pressed) begin
                  state <= RELEASED;
               end else if (deb_cnt == DEB_LAST) begin
                  state       <= PRESSED;
                  press_pulse <= 1'b1;
                  btn_level   <= 1'b1;
                  press_count <= press_count + 8'd1;
                  hold_cnt    <= '0;
                  long_seen   <= 1'b0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            PRESSED: begin
               // Release wins over a long-press landing in the same cycle.
               if (!sync_pressed) begin
                  state   <= RELEASE_WAIT;
                  deb_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state      <= LONG_HELD;
                  long_pulse <= 1'b1;
                  long_seen  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            LONG_HELD: begin
               if (!sync_pressed) begin
                  state   <= RELEASE_WAIT;
                  deb_cnt <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (sync_pressed) begin
                  state <= long_seen ? LONG_HELD : PRESSED;
               end else if (deb_cnt == DEB_LAST) begin
                  state         <= RELEASED;
                  release_pulse <= 1'b1;
                  btn_level     <= 1'b0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000, cycles of stable input required to accept a level change (10 ms at 12 MHz); legal range is 1 or more.
REQ-002 SHALL have parameter LONG_CYCLES, default 12000000, cycles held in the pressed state before a long-press is flagged (1 s at 12 MHz); legal range is 1 or more.
REQ-003 Port clk, input, 1 bit: the single clock, driven from CLK_12M.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port btn_n_in, input, 1 bit: raw asynchronous USER_BTN_N pin; 0 means pressed.
REQ-006 Port btn_level, output, 1 bit: debounced level, active-high (1 means pressed); feeds the LED-select mux.
REQ-007 Port press_pulse, output, 1 bit: one-cycle strobe when a press is accepted.
REQ-008 Port release_pulse, output, 1 bit: one-cycle strobe when a release is accepted.
REQ-009 Port long_pulse, output, 1 bit: one-cycle strobe when a long-press is reached.
REQ-010 Port press_count, output, 8 bits: number of accepted presses, modulo 256.

Function
REQ-011 btn_n_in SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic SHALL use only the synchronized value (sync_pressed = not synchronized btn_n_in).
REQ-012 FSM states SHALL be RELEASED, PRESS_WAIT, PRESSED, LONG_HELD and RELEASE_WAIT, with one shared debounce counter (deb_cnt) and one hold counter (hold_cnt).
REQ-013 RELEASED: btn_level=0; when sync_pressed=1, go to PRESS_WAIT with deb_cnt=0.
REQ-014 PRESS_WAIT: when sync_pressed=0, return to RELEASED (bounce rejected, no pulse); otherwise, when deb_cnt=DEBOUNCE_CYCLES-1, go to PRESSED; otherwise increment deb_cnt.
REQ-015 Entering PRESSED SHALL register press_pulse=1 for exactly one cycle, set btn_level=1, increment press_count (255 wraps to 0) and clear hold_cnt.
REQ-016 PRESSED: when sync_pressed=0, go to RELEASE_WAIT with deb_cnt=0; otherwise, when hold_cnt=LONG_CYCLES-1, go to LONG_HELD with long_pulse=1 for one cycle; otherwise increment hold_cnt.
REQ-017 Release SHALL have priority: if sync_pressed=0 in the same cycle hold_cnt reaches LONG_CYCLES-1, the FSM goes to RELEASE_WAIT and long_pulse is not asserted.
REQ-018 LONG_HELD: when sync_pressed=0, go to RELEASE_WAIT with deb_cnt=0; hold_cnt is frozen.
REQ-019 RELEASE_WAIT: btn_level stays 1 and hold_cnt is frozen.
REQ-020 RELEASE_WAIT, bounce case: when sync_pressed=1, return to the state it came from (PRESSED or LONG_HELD, held in a 1-bit long_seen flag) with no pulses.
REQ-021 RELEASE_WAIT, accept case: when deb_cnt=DEBOUNCE_CYCLES-1, go to RELEASED with release_pulse=1 for one cycle and btn_level=0; otherwise increment deb_cnt.
REQ-022 Press latency SHALL be fixed: with btn_n_in low and stable from clock edge 0, press_pulse is high in the cycle after edge DEBOUNCE_CYCLES+2; release latency is identical.
REQ-023 long_pulse SHALL fire at most once per press.
REQ-024 At most one of press_pulse, release_pulse and long_pulse SHALL be high in any cycle.
REQ-025 All outputs SHALL be registered.
REQ-026 Counter widths SHALL be computed as clog2 of the respective parameter, with a minimum of 1 bit.

Reset
REQ-027 While rst=1, asynchronously: FSM=RELEASED, both synchronizer flops=1, deb_cnt=0, hold_cnt=0, long_seen=0, btn_level=0, all pulses=0, press_count=0.
REQ-028 Reset asserted mid-press SHALL abort with no pulses; after deassertion a still-held button SHALL be re-debounced as a new press.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef and the default timing constants (12 MHz clock, 10 ms debounce, 1 s long-press).
REQ-030 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with a reset-value parameter so it can be reused for UART_RX.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-031 Clean press: drive btn_n_in low at edge 0 and hold it -> press_pulse high only in cycle 6, btn_level=1 from cycle 6, press_count=1.
REQ-032 Bounce rejection: low for 3 cycles, high for 1, repeated 5 times -> no pulses, btn_level stays 0, press_count=0.
REQ-033 Long press: hold low for 40 cycles -> press_pulse in cycle 6, long_pulse in cycle 26, exactly once; then release -> release_pulse 6 cycles after the release edge.
REQ-034 Release bounce while in LONG_HELD: high for 2 cycles, then low again -> no release_pulse and no second long_pulse.
REQ-035 Wrap and reset: 256 clean presses -> press_count=0; assert rst during PRESS_WAIT -> all outputs 0 immediately, and a held button yields press_pulse 6 cycles after rst deasserts.
